// File: rtl/tpu_fifo_pkg.sv
// Shared weight type and sizing helper for the MMU weight FIFO bank.
package tpu_fifo_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] weight_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/weight_lane_fifo.sv
// Single-lane weight FIFO with registered read; data appears one cycle after i_pop.
// A full lane still accepts a push when the same-cycle pop frees a slot; rejected pushes assert o_drop.
module weight_lane_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_dat,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_drop,
    output logic [CNT_W-1:0]  o_level,
    output logic [DATA_W-1:0] o_rd_dat,
    output logic              o_rd_vld
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rd_dat;
    logic              r_rd_vld;
    logic              w_push_acc;

    assign o_full     = (r_cnt == CNT_W'(DEPTH));
    assign o_empty    = (r_cnt == '0);
    assign w_push_acc = i_push & (~o_full | i_pop);
    assign o_drop     = i_push & ~w_push_acc;
    assign o_level    = r_cnt;
    assign o_rd_dat   = r_rd_dat;
    assign o_rd_vld   = r_rd_vld;

    // When full, the write slot equals the read slot; the read samples the old entry.
    always_ff @(posedge clk) begin
        if (w_push_acc && !i_clear) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= i_pop;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_rd_dat <= r_mem[r_rd_ptr];
            end
            case ({w_push_acc, i_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/weight_fifo_bank.sv
// Bank of per-column weight FIFOs feeding the systolic MMU; a row pops from every lane at once.
// Lane i output lags the pop by 1+i cycles when SKEW_EN, else 1; no downstream backpressure.
module weight_fifo_bank
    import tpu_fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int LANES   = 4,
    parameter int SKEW_EN = 1,
    localparam int CNT_W  = cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic [LANES-1:0]        push_mask,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic                    pop,
    output logic                    row_ready,
    output logic [LANES-1:0]        full,
    output logic [LANES-1:0]        empty,
    output logic [LANES*CNT_W-1:0]  level,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        data_valid,
    output logic                    ovf_err,
    output logic                    unf_err
);

    logic [LANES-1:0]             w_empty;
    logic [LANES-1:0]             w_full;
    logic [LANES-1:0]             w_drop;
    logic [LANES-1:0]             w_rd_vld;
    logic [LANES-1:0][DATA_W-1:0] w_rd_dat;
    logic                         w_row_ready;
    logic                         w_pop_acc;
    logic                         r_ovf;
    logic                         r_unf;

    assign w_row_ready = &(~w_empty);
    assign w_pop_acc   = pop & w_row_ready;
    assign row_ready   = w_row_ready;
    assign full        = w_full;
    assign empty       = w_empty;
    assign ovf_err     = r_ovf;
    assign unf_err     = r_unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (clear) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (|w_drop);
            r_unf <= r_unf | (pop & ~w_row_ready);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        weight_lane_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_clear  (clear),
            .i_push   (push_mask[i]),
            .i_dat    (data_in[i*DATA_W +: DATA_W]),
            .i_pop    (w_pop_acc),
            .o_full   (w_full[i]),
            .o_empty  (w_empty[i]),
            .o_drop   (w_drop[i]),
            .o_level  (level[i*CNT_W +: CNT_W]),
            .o_rd_dat (w_rd_dat[i]),
            .o_rd_vld (w_rd_vld[i])
        );

        if (SKEW_EN != 0 && i > 0) begin : g_skew
            // Plain shift chain; data keeps shifting so the tail holds the last popped value.
            logic [i-1:0][DATA_W-1:0] r_sk_dat;
            logic [i-1:0]             r_sk_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sk_dat <= '0;
                    r_sk_vld <= '0;
                end else if (clear) begin
                    r_sk_dat <= '0;
                    r_sk_vld <= '0;
                end else begin
                    r_sk_dat[0] <= w_rd_dat[i];
                    r_sk_vld[0] <= w_rd_vld[i];
                    for (int k = 1; k < i; k++) begin
                        r_sk_dat[k] <= r_sk_dat[k-1];
                        r_sk_vld[k] <= r_sk_vld[k-1];
                    end
                end
            end

            assign data_out[i*DATA_W +: DATA_W] = r_sk_dat[i-1];
            assign data_valid[i]                = r_sk_vld[i-1];
        end else begin : g_noskew
            assign data_out[i*DATA_W +: DATA_W] = w_rd_dat[i];
            assign data_valid[i]                = w_rd_vld[i];
        end
    end

endmodule

// File: tb/tb_weight_fifo_bank.sv
// Self-checking bench for weight_fifo_bank against a queue-based reference model.
module tb_weight_fifo_bank;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int LANES  = 4;
    localparam int CNT_W  = 5;
    localparam int ST_W   = LANES*CNT_W + 2*LANES + 3;
    localparam int OUT_W  = LANES + LANES*DATA_W;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic [LANES-1:0]        push_mask;
    logic [LANES*DATA_W-1:0] data_in;
    logic                    pop;
    logic                    row_ready;
    logic [LANES-1:0]        full;
    logic [LANES-1:0]        empty;
    logic [LANES*CNT_W-1:0]  level;
    logic [LANES*DATA_W-1:0] data_out;
    logic [LANES-1:0]        data_valid;
    logic                    ovf_err;
    logic                    unf_err;

    always #5 clk = ~clk;

    weight_fifo_bank #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .LANES   (LANES),
        .SKEW_EN (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push_mask  (push_mask),
        .data_in    (data_in),
        .pop        (pop),
        .row_ready  (row_ready),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .data_out   (data_out),
        .data_valid (data_valid),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err)
    );

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    // Reference model: per-lane contents, scheduled output events (cycle, value), sticky flags.
    logic [DATA_W-1:0] mq     [LANES][$];
    int                ev_cyc [LANES][$];
    logic [DATA_W-1:0] ev_dat [LANES][$];
    logic [DATA_W-1:0] last_dat [LANES];
    bit                m_ovf, m_unf;

    logic [OUT_W-1:0] exp_out;
    logic [ST_W-1:0]  exp_st;
    wire  [OUT_W-1:0] obs_out = {data_valid, data_out};
    wire  [ST_W-1:0]  obs_st  = {level, full, empty, row_ready, ovf_err, unf_err};

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            mq[i].delete();
            ev_cyc[i].delete();
            ev_dat[i].delete();
            last_dat[i] = '0;
        end
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_edge(input logic [LANES-1:0] pm, input logic [LANES*DATA_W-1:0] din,
                              input logic p, input logic clr);
        bit rr, pacc, acc;
        if (clr) begin
            model_reset();
            return;
        end
        rr = 1'b1;
        for (int i = 0; i < LANES; i++) if (mq[i].size() == 0) rr = 1'b0;
        pacc = p && rr;
        if (p && !rr) m_unf = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            acc = pm[i] && (mq[i].size() < DEPTH || pacc);
            if (pm[i] && !acc) m_ovf = 1'b1;
            if (pacc) begin
                ev_cyc[i].push_back(cyc + i);
                ev_dat[i].push_back(mq[i].pop_front());
            end
            if (acc) mq[i].push_back(din[i*DATA_W +: DATA_W]);
        end
    endtask

    task automatic model_outputs();
        logic [LANES-1:0]       vld, fl, em;
        logic [LANES*CNT_W-1:0] lv;
        logic [LANES*DATA_W-1:0] dq;
        for (int i = 0; i < LANES; i++) begin
            vld[i] = 1'b0;
            if (ev_cyc[i].size() > 0 && ev_cyc[i][0] == cyc) begin
                vld[i]      = 1'b1;
                last_dat[i] = ev_dat[i].pop_front();
                void'(ev_cyc[i].pop_front());
            end
            dq[i*DATA_W +: DATA_W] = last_dat[i];
            lv[i*CNT_W +: CNT_W]   = CNT_W'(mq[i].size());
            fl[i] = (mq[i].size() == DEPTH);
            em[i] = (mq[i].size() == 0);
        end
        exp_out = {vld, dq};
        exp_st  = {lv, fl, em, ~|em, m_ovf, m_unf};
    endtask

    // Drive one cycle of stimulus, let the edge happen, observe at the following negedge.
    task automatic tick(input logic [LANES-1:0] pm, input logic [LANES*DATA_W-1:0] din,
                        input logic p, input logic clr);
        push_mask = pm;
        data_in   = din;
        pop       = p;
        clear     = clr;
        @(posedge clk);
        cyc++;
        model_edge(pm, din, p, clr);
        @(negedge clk);
        push_mask = '0;
        pop       = 1'b0;
        clear     = 1'b0;
        model_outputs();
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; push_mask = '0; data_in = '0; pop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_outputs();
        if (obs_out !== {OUT_W{1'b0}}) begin
            nfail++; $display("FAIL reset_out got=%h exp=0", obs_out);
        end
        ncmp++;
        if (obs_st !== {{LANES*CNT_W{1'b0}}, 4'h0, 4'hF, 3'b000}) begin
            nfail++; $display("FAIL reset_status got=%h exp=%h", obs_st, {{LANES*CNT_W{1'b0}}, 4'h0, 4'hF, 3'b000});
        end
        ncmp++;
    endtask

    task automatic test_fill_drain();
        int k_next [LANES];
        for (int i = 0; i < LANES; i++) k_next[i] = 0;
        for (int k = 0; k < DEPTH; k++) tick(4'hF, {LANES{8'(8'h10 + k)}}, 1'b0, 1'b0);
        if (level !== {LANES{5'd16}} || full !== 4'hF) begin
            nfail++; $display("FAIL fill_level got=%h/%h exp=%h/f", level, full, {LANES{5'd16}});
        end
        ncmp++;
        for (int t = 0; t < DEPTH + LANES; t++) begin
            tick('0, '0, t < DEPTH, 1'b0);
            if (obs_out !== exp_out) begin
                nfail++; $display("FAIL drain_out cyc=%0d got=%h exp=%h", cyc, obs_out, exp_out);
            end
            ncmp++;
            for (int i = 0; i < LANES; i++) begin
                if (data_valid[i]) begin
                    if (data_out[i*DATA_W +: DATA_W] !== 8'(8'h10 + k_next[i])) begin
                        nfail++; $display("FAIL drain_seq lane=%0d got=%h exp=%h", i,
                                          data_out[i*DATA_W +: DATA_W], 8'(8'h10 + k_next[i]));
                    end
                    ncmp++;
                    k_next[i]++;
                end
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (k_next[i] != DEPTH) begin
                nfail++; $display("FAIL drain_count lane=%0d got=%0d exp=%0d", i, k_next[i], DEPTH);
            end
            ncmp++;
        end
        if (empty !== 4'hF || obs_st !== exp_st) begin
            nfail++; $display("FAIL drain_empty got=%h exp=%h", obs_st, exp_st);
        end
        ncmp++;
    endtask

    task automatic test_partial();
        int nv = 0;
        tick(4'h7, 32'($urandom), 1'b0, 1'b0);
        if (row_ready !== 1'b0) begin
            nfail++; $display("FAIL partial_rr got=%b exp=0", row_ready);
        end
        ncmp++;
        tick('0, '0, 1'b1, 1'b0);
        if (unf_err !== 1'b1 || obs_st !== exp_st) begin
            nfail++; $display("FAIL partial_unf got=%h exp=%h", obs_st, exp_st);
        end
        ncmp++;
        repeat (LANES) begin
            tick('0, '0, 1'b0, 1'b0);
            if (data_valid !== 4'h0) begin
                nfail++; $display("FAIL partial_novalid got=%h exp=0", data_valid);
            end
            ncmp++;
        end
        tick(4'h8, 32'($urandom), 1'b0, 1'b0);
        if (row_ready !== 1'b1) begin
            nfail++; $display("FAIL partial_rr2 got=%b exp=1", row_ready);
        end
        ncmp++;
        for (int t = 0; t < LANES + 1; t++) begin
            tick('0, '0, t == 0, 1'b0);
            nv += $countones(data_valid);
            if (obs_out !== exp_out) begin
                nfail++; $display("FAIL partial_out cyc=%0d got=%h exp=%h", cyc, obs_out, exp_out);
            end
            ncmp++;
        end
        if (nv != LANES) begin
            nfail++; $display("FAIL partial_row got=%0d exp=%0d", nv, LANES);
        end
        ncmp++;
        tick('0, '0, 1'b0, 1'b1);
        if (obs_st !== exp_st || unf_err !== 1'b0) begin
            nfail++; $display("FAIL partial_clear got=%h exp=%h", obs_st, exp_st);
        end
        ncmp++;
    endtask

    task automatic test_overflow();
        bit saw_aa = 1'b0;
        repeat (DEPTH) tick(4'h1, {24'($urandom), 8'($urandom_range(0, 8'h7F))}, 1'b0, 1'b0);
        tick(4'h1, 32'h0000_00AA, 1'b0, 1'b0);
        if (ovf_err !== 1'b1 || level[CNT_W-1:0] !== 5'd16 || obs_st !== exp_st) begin
            nfail++; $display("FAIL ovf_flag got=%b/%0d exp=1/16", ovf_err, level[CNT_W-1:0]);
        end
        ncmp++;
        repeat (DEPTH) tick(4'hE, {24'($urandom), 8'h00}, 1'b0, 1'b0);
        for (int t = 0; t < DEPTH + LANES; t++) begin
            tick('0, '0, t < DEPTH, 1'b0);
            if (data_valid[0] && data_out[DATA_W-1:0] === 8'hAA) saw_aa = 1'b1;
            if (obs_out !== exp_out) begin
                nfail++; $display("FAIL ovf_out cyc=%0d got=%h exp=%h", cyc, obs_out, exp_out);
            end
            ncmp++;
        end
        if (saw_aa !== 1'b0) begin
            nfail++; $display("FAIL ovf_dropped got=%b exp=0", saw_aa);
        end
        ncmp++;
        tick('0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        int n0 = 0;
        logic [DATA_W-1:0] last0 = '0;
        logic [DATA_W-1:0] last3 = '0;
        repeat (DEPTH) tick(4'hF, 32'($urandom), 1'b0, 1'b0);
        for (int t = 0; t < DEPTH + 1 + LANES; t++) begin
            if (t == 0) tick(4'hF, {LANES{8'h55}}, 1'b1, 1'b0);
            else        tick('0, '0, t <= DEPTH, 1'b0);
            if (t == 0 && (ovf_err !== 1'b0 || level !== {LANES{5'd16}})) begin
                nfail++; $display("FAIL fpp_accept got=%b/%h exp=0/%h", ovf_err, level, {LANES{5'd16}});
            end
            if (t == 0) ncmp++;
            if (data_valid[0]) begin n0++; last0 = data_out[DATA_W-1:0]; end
            if (data_valid[3]) last3 = data_out[3*DATA_W +: DATA_W];
            if (obs_out !== exp_out) begin
                nfail++; $display("FAIL fpp_out cyc=%0d got=%h exp=%h", cyc, obs_out, exp_out);
            end
            ncmp++;
        end
        if (n0 != DEPTH + 1 || last0 !== 8'h55 || last3 !== 8'h55) begin
            nfail++; $display("FAIL fpp_order got=%0d/%h/%h exp=17/55/55", n0, last0, last3);
        end
        ncmp++;
        if (empty !== 4'hF || ovf_err !== 1'b0) begin
            nfail++; $display("FAIL fpp_end got=%h/%b exp=f/0", empty, ovf_err);
        end
        ncmp++;
    endtask

    task automatic test_wrap();
        logic [LANES-1:0] pm;
        bit rr, p;
        repeat (2) tick(4'hF, 32'($urandom), 1'b0, 1'b0);
        for (int t = 0; t < 40; t++) begin
            rr = 1'b1;
            for (int i = 0; i < LANES; i++) begin
                pm[i] = (mq[i].size() < 3) && ($urandom_range(0, 3) != 0);
                if (mq[i].size() == 0) rr = 1'b0;
            end
            p = rr && ($urandom_range(0, 3) != 0);
            tick(pm, 32'($urandom), p, 1'b0);
            if (obs_out !== exp_out || obs_st !== exp_st) begin
                nfail++; $display("FAIL wrap cyc=%0d out=%h/%h st=%h/%h", cyc, obs_out, exp_out, obs_st, exp_st);
            end
            ncmp++;
        end
        for (int t = 0; t < 4 + LANES; t++) begin
            tick('0, '0, row_ready, 1'b0);
            if (obs_out !== exp_out || obs_st !== exp_st) begin
                nfail++; $display("FAIL wrap_drain cyc=%0d out=%h/%h st=%h/%h", cyc, obs_out, exp_out, obs_st, exp_st);
            end
            ncmp++;
        end
        tick('0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_clear_mid();
        tick('0, '0, 1'b1, 1'b0);
        repeat (3) tick(4'hF, 32'($urandom), 1'b0, 1'b0);
        tick('0, '0, 1'b1, 1'b0);
        if (obs_out !== exp_out || data_valid !== 4'h1) begin
            nfail++; $display("FAIL clr_pop got=%h exp=%h", obs_out, exp_out);
        end
        ncmp++;
        tick('0, '0, 1'b0, 1'b1);
        if (obs_st !== exp_st || level !== '0 || unf_err !== 1'b0) begin
            nfail++; $display("FAIL clr_state got=%h exp=%h", obs_st, exp_st);
        end
        ncmp++;
        repeat (LANES + 1) begin
            tick('0, '0, 1'b0, 1'b0);
            if (data_valid !== 4'h0 || obs_out !== exp_out) begin
                nfail++; $display("FAIL clr_novalid got=%h exp=%h", obs_out, exp_out);
            end
            ncmp++;
        end
    endtask

    task automatic test_rst_mid();
        tick(4'h2, 32'($urandom), 1'b0, 1'b0);
        tick(4'h2, 32'($urandom), 1'b0, 1'b0);
        tick(4'h2, 32'($urandom), 1'b0, 1'b0);
        repeat (3) tick(4'hF, 32'($urandom), 1'b0, 1'b0);
        tick('0, '0, 1'b1, 1'b0);
        if (ovf_err !== 1'b0 || obs_out !== exp_out) begin
            nfail++; $display("FAIL rst_pre got=%h exp=%h", obs_out, exp_out);
        end
        ncmp++;
        #2 rst = 1'b1;
        model_reset();
        #1;
        model_outputs();
        if (obs_out !== exp_out || obs_st !== exp_st) begin
            nfail++; $display("FAIL rst_async out=%h/%h st=%h/%h", obs_out, exp_out, obs_st, exp_st);
        end
        ncmp++;
        #1 rst = 1'b0;
        repeat (LANES + 1) begin
            tick('0, '0, 1'b0, 1'b0);
            if (data_valid !== 4'h0 || obs_out !== exp_out || obs_st !== exp_st) begin
                nfail++; $display("FAIL rst_novalid out=%h/%h st=%h/%h", obs_out, exp_out, obs_st, exp_st);
            end
            ncmp++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_partial();
        test_overflow();
        test_full_push_pop();
        test_wrap();
        test_clear_mid();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
